ddr4_dqsw_lvl_ctrl: RTL and testbench
=====================================

# ddr4_dqsw_lvl_ctrl

Write-leveling training controller for one DDR4 byte lane's DQSW strobe IOD. It sits in fabric on FAB_CLK and drives that IOD's dynamic delay-line controls and TX/OE strobe data. It samples the IOD's RX_DATA feedback and sweeps the output delay tap by tap until the DRAM-reported CK level changes from 0 to 1. It then reports the first tap where that happens, or reports a failure.

## Interface
- MAX_TAPS, 128: delay-line taps swept; TAP_W = $clog2(MAX_TAPS).
- SETTLE_CYCLES, 8: FAB_CLK cycles waited after each strobe before sampling (≥1).
- SAMPLES, 5: strobes per tap for the majority vote (odd, ≥1).

- FAB_CLK  in  1  sole clock.
- RESET_N  in  1  synchronous active-low reset.
- START  in  1  begin training; accepted only in IDLE.
- BUSY  out  1  high from the cycle after START is accepted until DONE or FAIL is raised.
- DONE  out  1  training succeeded; held until next accepted START.
- FAIL  out  1  no transition found; held until next accepted START.
- TAP_RESULT  out  TAP_W  tap index of the first 0→1 transition; valid while DONE.
- DELAY_LINE_LOAD  out  1  one-cycle pulse that resets the IOD delay to its static value (tap 0).
- DELAY_LINE_MOVE  out  1  one-cycle pulse that steps the delay by one tap.
- DELAY_LINE_DIRECTION  out  1  always 1 (increment) while BUSY, otherwise 0.
- DELAY_LINE_OUT_OF_RANGE  in  1  from IOD.
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse in LOAD.
- TX_DATA  out  2  strobe data to IOD; 2'b01 during STROBE, else 2'b00.
- OE_DATA  out  2  2'b11 during STROBE, else 2'b00.
- RX_DATA  in  2  DRAM feedback; bit 0 is the sampled value.

## Operation
- States: IDLE, LOAD, STROBE, SETTLE, SAMPLE, EVAL, MOVE, FINISH.
- IDLE, START=1 → LOAD:
  - clear DONE and FAIL;
  - tap_cnt=0, seen_zero=0, ones=0, samp_cnt=0.
- LOAD: assert DELAY_LINE_LOAD and EYE_MONITOR_CLEAR_FLAGS for 1 cycle → STROBE.
- STROBE: drive TX_DATA=01 and OE_DATA=11 for 1 cycle → SETTLE.
- SETTLE: count SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE (1 cycle):
  - ones += RX_DATA[0]; samp_cnt++;
  - if samp_cnt==SAMPLES-1 → EVAL, else → STROBE.
- EVAL: vote = (ones > SAMPLES/2).
  - vote=1 and seen_zero=1 → FINISH with DONE=1 and TAP_RESULT=tap_cnt.
  - vote=0 → seen_zero=1.
  - Otherwise, if tap_cnt==MAX_TAPS-1 or DELAY_LINE_OUT_OF_RANGE=1 → FINISH with FAIL=1.
  - Otherwise → MOVE.
- MOVE: pulse DELAY_LINE_MOVE, tap_cnt++, ones=0, samp_cnt=0 → STROBE.
- FINISH: BUSY=0 → IDLE.
- A vote of 1 before any 0 is seen is not a transition: keep sweeping.
- START while not in IDLE is ignored.

## Timing
- All outputs are registered. Reset value of every output is 0: BUSY, DONE, FAIL, TAP_RESULT, LOAD, MOVE, DIRECTION, CLEAR_FLAGS, TX_DATA, OE_DATA.
- RESET_N low in any state: on the next edge, state=IDLE, all counters and flags are zero, and pulses are deasserted. No partial MOVE is issued.
- START sampled high in IDLE at edge N:
  - BUSY=1 and DELAY_LINE_LOAD=1 after edge N+1;
  - STROBE after edge N+2.
- Per tap: SAMPLES×(2+SETTLE_CYCLES) cycles, plus EVAL (1) and MOVE (1).
- MOVE is never asserted in the same cycle as LOAD or STROBE.
- DONE/FAIL rise in the same cycle that BUSY falls.
- OUT_OF_RANGE is only evaluated in EVAL.
- Counter widths: tap_cnt is TAP_W bits and never wraps, because the terminal check precedes MOVE. ones and samp_cnt are $clog2(SAMPLES+1) bits.

## Structure
- Package ddr4_dqsw_lvl_pkg: state enum; TX_STROBE=2'b01 and OE_ON=2'b11 constants.
- Sub-module ddr4_dqsw_vote: ones counter, samp_cnt and majority comparator, with clear/inc/last/vote ports.

## Test plan
- IOD model returns 0 for taps 0–36 and 1 from tap 37 (SAMPLES=5, SETTLE_CYCLES=8) → 1 LOAD and 37 MOVE pulses, DONE=1, TAP_RESULT=37, FAIL=0.
- Model returns 1 at taps 0–9, 0 at 10–19, 1 from 20 → TAP_RESULT=20, not 0.
- Model returns constant 0 with MAX_TAPS=16 → exactly 15 MOVE pulses, then FAIL=1, DONE=0.
- Transition at tap 50, OUT_OF_RANGE forced high at tap 12 → FAIL=1 after EVAL of tap 12; no further MOVE.
- Majority vote: at tap 5, samples 1,0,1,0,1 → vote=1; samples 1,0,0,1,0 → vote=0.
- RESET_N low for 1 cycle during SETTLE at tap 20 → all outputs 0 on the next edge; a new START restarts with a LOAD pulse, and START pulses while BUSY are ignored.

Source files
------------

// File: rtl/ddr4_dqsw_lvl_pkg.sv
// Shared types and strobe encodings for the DQSW write-leveling controller.
package ddr4_dqsw_lvl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STROBE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_MOVE,
        ST_FINISH
    } lvl_state_t;

    localparam logic [1:0] TX_STROBE = 2'b01;
    localparam logic [1:0] TX_OFF    = 2'b00;
    localparam logic [1:0] OE_ON     = 2'b11;
    localparam logic [1:0] OE_OFF    = 2'b00;

endpackage

// File: rtl/ddr4_dqsw_vote.sv
// Majority vote over SAMPLES feedback bits of one tap.
// last/vote are combinational off the counters; counters update on inc, zero on clear.
module ddr4_dqsw_vote #(
    parameter int SAMPLES = 5,
    localparam int CNT_W = $clog2(SAMPLES + 1)
) (
    input  logic FAB_CLK,
    input  logic RESET_N,
    input  logic clear,
    input  logic inc,
    input  logic sample_bit,
    output logic last,
    output logic vote
);

    logic [CNT_W-1:0] ones;
    logic [CNT_W-1:0] samp_cnt;

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            ones     <= '0;
            samp_cnt <= '0;
        end else if (clear) begin
            ones     <= '0;
            samp_cnt <= '0;
        end else if (inc) begin
            ones     <= ones + CNT_W'(sample_bit);
            samp_cnt <= samp_cnt + CNT_W'(1);
        end
    end

    // last looks at the pre-increment count, so it is true while taking the final sample
    assign last = (samp_cnt == CNT_W'(SAMPLES - 1));
    assign vote = (ones > CNT_W'(SAMPLES / 2));

endmodule

// File: rtl/ddr4_dqsw_lvl_ctrl.sv
// Write-leveling sweep for one byte lane's DQSW IOD: finds first 0->1 CK level tap.
// All outputs registered off the current state, so they trail the state by one cycle.
module ddr4_dqsw_lvl_ctrl
    import ddr4_dqsw_lvl_pkg::*;
#(
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 5,
    localparam int TAP_W = $clog2(MAX_TAPS)
) (
    input  logic             FAB_CLK,
    input  logic             RESET_N,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [TAP_W-1:0] TAP_RESULT,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    output logic [1:0]       TX_DATA,
    output logic [1:0]       OE_DATA,
    input  logic [1:0]       RX_DATA
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    lvl_state_t       state_q, state_d;
    logic [TAP_W-1:0] tap_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic             seen_zero, win;
    logic             vote_clear, vote_inc, vote_last, vote;
    logic             start_acc, settle_done, at_last_tap;
    logic             busy_d, load_d, move_d;
    logic [1:0]       tx_d, oe_d;
    logic             rx_unused;

    assign start_acc   = (state_q == ST_IDLE) && START;
    assign settle_done = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
    assign at_last_tap = (tap_cnt == TAP_W'(MAX_TAPS - 1));
    assign vote_clear  = (state_q == ST_IDLE) || (state_q == ST_MOVE);
    assign vote_inc    = (state_q == ST_SAMPLE);
    assign rx_unused   = RX_DATA[1];

    ddr4_dqsw_vote #(.SAMPLES(SAMPLES)) u_vote (
        .FAB_CLK    (FAB_CLK),
        .RESET_N    (RESET_N),
        .clear      (vote_clear),
        .inc        (vote_inc),
        .sample_bit (RX_DATA[0]),
        .last       (vote_last),
        .vote       (vote)
    );

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (START) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_STROBE;
            ST_STROBE: state_d = ST_SETTLE;
            ST_SETTLE: if (settle_done) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = vote_last ? ST_EVAL : ST_STROBE;
            // terminal check sits before MOVE, which is what keeps tap_cnt from wrapping
            ST_EVAL: begin
                if (vote && seen_zero)                           state_d = ST_FINISH;
                else if (at_last_tap || DELAY_LINE_OUT_OF_RANGE) state_d = ST_FINISH;
                else                                             state_d = ST_MOVE;
            end
            ST_MOVE:   state_d = ST_STROBE;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            tap_cnt    <= '0;
            settle_cnt <= '0;
            seen_zero  <= 1'b0;
            win        <= 1'b0;
        end else begin
            if (start_acc) begin
                tap_cnt   <= '0;
                seen_zero <= 1'b0;
                win       <= 1'b0;
            end
            if (state_q == ST_SETTLE)
                settle_cnt <= settle_done ? '0 : settle_cnt + SET_W'(1);
            if (state_q == ST_EVAL) begin
                if (vote && seen_zero) win       <= 1'b1;
                else if (!vote)        seen_zero <= 1'b1;
            end
            if (state_q == ST_MOVE)
                tap_cnt <= tap_cnt + TAP_W'(1);
        end
    end

    always_comb begin
        busy_d = (state_q != ST_IDLE) && (state_q != ST_FINISH);
        load_d = (state_q == ST_LOAD);
        move_d = (state_q == ST_MOVE);
        tx_d   = (state_q == ST_STROBE) ? TX_STROBE : TX_OFF;
        oe_d   = (state_q == ST_STROBE) ? OE_ON : OE_OFF;
    end

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            BUSY                    <= 1'b0;
            DONE                    <= 1'b0;
            FAIL                    <= 1'b0;
            TAP_RESULT              <= '0;
            DELAY_LINE_LOAD         <= 1'b0;
            DELAY_LINE_MOVE         <= 1'b0;
            DELAY_LINE_DIRECTION    <= 1'b0;
            EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
            TX_DATA                 <= TX_OFF;
            OE_DATA                 <= OE_OFF;
        end else begin
            BUSY                    <= busy_d;
            DELAY_LINE_LOAD         <= load_d;
            DELAY_LINE_MOVE         <= move_d;
            DELAY_LINE_DIRECTION    <= busy_d;
            EYE_MONITOR_CLEAR_FLAGS <= load_d;
            TX_DATA                 <= tx_d;
            OE_DATA                 <= oe_d;
            // FINISH is the cycle BUSY drops, so DONE/FAIL land on the same edge
            if (start_acc) begin
                DONE       <= 1'b0;
                FAIL       <= 1'b0;
                TAP_RESULT <= '0;
            end else if (state_q == ST_FINISH) begin
                DONE <= win;
                FAIL <= !win;
                if (win) TAP_RESULT <= tap_cnt;
            end
        end
    end

endmodule

// File: tb/tb_ddr4_dqsw_lvl_ctrl.sv
// Bench: IOD feedback model driven by per-tap sample tables, checked against a sweep reference.
module tb_ddr4_dqsw_lvl_ctrl;

    localparam int NTAPS  = 128;
    localparam int NSAMP  = 5;
    localparam int SETTLE = 8;
    localparam int PER    = NSAMP * (2 + SETTLE) + 2;

    logic       FAB_CLK = 1'b0;
    logic       RESET_N;
    logic       START;
    logic       BUSY, DONE, FAIL;
    logic [6:0] TAP_RESULT;
    logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_OUT_OF_RANGE;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic [1:0] TX_DATA, OE_DATA, RX_DATA;

    ddr4_dqsw_lvl_ctrl dut (
        .FAB_CLK                 (FAB_CLK),
        .RESET_N                 (RESET_N),
        .START                   (START),
        .BUSY                    (BUSY),
        .DONE                    (DONE),
        .FAIL                    (FAIL),
        .TAP_RESULT              (TAP_RESULT),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
        .TX_DATA                 (TX_DATA),
        .OE_DATA                 (OE_DATA),
        .RX_DATA                 (RX_DATA)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    logic [NSAMP-1:0] smp [NTAPS];
    int oor_tap = 1000;
    int mtap = 0, sidx = 0;
    int loads = 0, moves = 0, overlap = 0;
    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] all_outs();
        return {BUSY, DONE, FAIL, TAP_RESULT, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS, TX_DATA, OE_DATA};
    endfunction

    // IOD model: tracks the tap from LOAD/MOVE pulses and answers each strobe from the table
    initial begin
        RX_DATA = 2'b00;
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        forever begin
            @(posedge FAB_CLK);
            #1;
            if (DELAY_LINE_MOVE === 1'b1 && (DELAY_LINE_LOAD === 1'b1 || TX_DATA !== 2'b00))
                overlap++;
            if (DELAY_LINE_LOAD === 1'b1) begin
                mtap = 0; sidx = 0; loads++;
            end
            if (DELAY_LINE_MOVE === 1'b1) begin
                if (mtap < NTAPS - 1) mtap++;
                sidx = 0; moves++;
            end
            if (TX_DATA === 2'b01) begin
                RX_DATA = {1'($urandom), (sidx < NSAMP) ? smp[mtap][sidx] : 1'b0};
                sidx++;
            end
            DELAY_LINE_OUT_OF_RANGE = (mtap >= oor_tap);
        end
    end

    // Reference sweep: first majority-1 tap after any majority-0 tap, else fail at end/out-of-range
    function automatic void model(output bit done, output int t_end);
        bit seen = 0;
        done = 0;
        t_end = NTAPS - 1;
        for (int t = 0; t < NTAPS; t++) begin
            bit v = ($countones(smp[t]) > NSAMP / 2);
            if (v && seen) begin done = 1; t_end = t; return; end
            if (!v) seen = 1;
            if (t == NTAPS - 1 || t >= oor_tap) begin t_end = t; return; end
        end
    endfunction

    task automatic fill_step(input int lo_end, input logic [NSAMP-1:0] lo, input logic [NSAMP-1:0] hi);
        for (int t = 0; t < NTAPS; t++) smp[t] = (t < lo_end) ? lo : hi;
    endtask

    task automatic run(input string nm, input bit spam);
        bit edone;
        int et, cyc;
        model(edone, et);
        loads = 0; moves = 0; overlap = 0;
        START = 1'b1;
        @(posedge FAB_CLK); #1;
        START = 1'b0;
        cyc = 1;
        chk({nm, "_clr"}, {30'd0, DONE, FAIL}, 0);
        while (!(DONE === 1'b1 || FAIL === 1'b1) && cyc < 10000) begin
            if (cyc == 2)
                chk({nm, "_busy_load"}, {BUSY, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS}, 4'b1111);
            if (cyc == 3)
                chk({nm, "_strobe"}, {TX_DATA, OE_DATA}, 4'b0111);
            START = (spam && (cyc % 61 == 7)) ? 1'b1 : 1'b0;
            @(posedge FAB_CLK); #1;
            cyc++;
        end
        START = 1'b0;
        chk({nm, "_cycles"}, cyc, 2 + PER * (et + 1));
        chk({nm, "_done"}, DONE, edone);
        chk({nm, "_fail"}, FAIL, !edone);
        chk({nm, "_busy_end"}, BUSY, 0);
        if (edone) chk({nm, "_tap"}, TAP_RESULT, et);
        repeat (3) @(posedge FAB_CLK);
        #1;
        chk({nm, "_moves"}, moves, et);
        chk({nm, "_loads"}, loads, 1);
        chk({nm, "_overlap"}, overlap, 0);
        chk({nm, "_hold"}, {DONE, FAIL}, {edone, !edone});
    endtask

    initial begin
        int g, trans, pre, p;
        RESET_N = 1'b0;
        START = 1'b0;
        fill_step(NTAPS, '0, '0);
        repeat (3) @(posedge FAB_CLK);
        #1;
        chk("reset_outs", all_outs(), 0);
        RESET_N = 1'b1;
        @(posedge FAB_CLK); #1;
        chk("idle_outs", all_outs(), 0);

        fill_step(37, 5'b00000, 5'b11111);
        oor_tap = 1000;
        run("step37", 0);

        fill_step(10, 5'b11111, 5'b00000);
        for (int t = 20; t < NTAPS; t++) smp[t] = 5'b11111;
        run("one_zero_one", 0);

        fill_step(NTAPS, '0, '0);
        run("const0", 0);

        fill_step(50, 5'b00000, 5'b11111);
        oor_tap = 12;
        run("oor12", 0);
        oor_tap = 1000;

        fill_step(5, 5'b00000, 5'b11111);
        smp[5] = 5'b10101;
        run("vote_10101", 0);

        fill_step(5, 5'b11111, 5'b11111);
        smp[5] = 5'b01001;
        run("vote_10010", 0);

        // reset mid-SETTLE at tap 20, then restart while spamming START
        fill_step(50, 5'b00000, 5'b11111);
        START = 1'b1;
        @(posedge FAB_CLK); #1;
        START = 1'b0;
        g = 0;
        while (!(mtap == 20 && TX_DATA === 2'b01) && g < 5000) begin
            @(posedge FAB_CLK); #1;
            g++;
        end
        chk("rst_reach_tap20", g < 5000, 1);
        @(posedge FAB_CLK); #1;
        RESET_N = 1'b0;
        @(posedge FAB_CLK); #1;
        chk("rst_mid_outs", all_outs(), 0);
        RESET_N = 1'b1;
        @(posedge FAB_CLK); #1;
        chk("rst_after_outs", all_outs(), 0);
        run("restart", 1);

        for (int r = 0; r < 6; r++) begin
            trans = $urandom_range(1, NTAPS - 1);
            pre = ($urandom_range(0, 1) == 1) ? $urandom_range(0, trans / 2) : 0;
            for (int t = 0; t < NTAPS; t++) begin
                p = (t < pre) ? 85 : (t < trans) ? 15 : 85;
                for (int s = 0; s < NSAMP; s++)
                    smp[t][s] = ($urandom_range(0, 99) < p);
            end
            oor_tap = ($urandom_range(0, 2) == 0) ? $urandom_range(3, NTAPS - 1) : 1000;
            run($sformatf("rand%0d", r), r[0]);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
